// File: rtl/alu_arbiter.sv
// Two-requester front end for one shared combinational ALU: grant, operand capture, result capture, done.
// Optional macro ALU_ARB_RR_EN selects round-robin tie breaking; undefined gives fixed priority to requester 0.
module alu_arbiter (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        req0,
   input  logic        req1,
   input  logic [3:0]  op0,
   input  logic [3:0]  op1,
   input  logic [31:0] a0,
   input  logic [31:0] b0,
   input  logic [31:0] a1,
   input  logic [31:0] b1,
   output logic        gnt0,
   output logic        gnt1,
   output logic        done0,
   output logic        done1,
   output logic [31:0] rsp_out,
   output logic        rsp_neg,
   output logic        rsp_ovf,
   output logic        rsp_zero,
   output logic [3:0]  alu_op,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   input  logic [31:0] alu_out,
   input  logic        alu_neg,
   input  logic        alu_overflow,
   input  logic        alu_zero,
   output logic        busy,
   output logic [15:0] op_cnt
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t state;
   state_t state_nxt;
   logic   owner;
   logic   pick1;

   // owner doubles as the last-served requester; it resets to 1 so requester 0 wins the first tie
   always_comb begin
`ifdef ALU_ARB_RR_EN
      pick1 = req1 && (!req0 || !owner);
`else
      pick1 = req1 && !req0;
`endif
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // grants are gated by nRST so a held request cannot leak a pulse while reset is asserted
   always_comb begin
      state_nxt = state;
      gnt0      = 1'b0;
      gnt1      = 1'b0;
      done0     = 1'b0;
      done1     = 1'b0;
      case (state)
         IDLE: begin
            if (nRST && (req0 || req1)) begin
               gnt0      = !pick1;
               gnt1      = pick1;
               state_nxt = EXEC;
            end
         end
         EXEC: begin
            state_nxt = RESP;
         end
         RESP: begin
            done0     = !owner;
            done1     = owner;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign busy = (state != IDLE);

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         owner    <= 1'b1;
         alu_op   <= '0;
         alu_a    <= '0;
         alu_b    <= '0;
         rsp_out  <= '0;
         rsp_neg  <= 1'b0;
         rsp_ovf  <= 1'b0;
         rsp_zero <= 1'b0;
         op_cnt   <= '0;
      end else begin
         if (gnt0 || gnt1) begin
            owner  <= gnt1;
            alu_op <= gnt1 ? op1 : op0;
            alu_a  <= gnt1 ? a1 : a0;
            alu_b  <= gnt1 ? b1 : b0;
         end
         if (state == EXEC) begin
            rsp_out  <= alu_out;
            rsp_neg  <= alu_neg;
            rsp_ovf  <= alu_overflow;
            rsp_zero <= alu_zero;
         end
         if (state == RESP) begin
            op_cnt <= op_cnt + 16'd1;
         end
      end
   end

   assert property (@(posedge CLK) disable iff (!nRST) !(gnt0 && gnt1));
   assert property (@(posedge CLK) disable iff (!nRST) !(done0 && done1));

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a stub ALU, a transaction-level reference model checked every cycle,
// and hand-computed literal expectations for the named scenarios.
module tb_alu_arbiter;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_AND = 4'd2;
   localparam logic [3:0] OP_OR  = 4'd3;
`ifdef ALU_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic        CLK  = 1'b0;
   logic        nRST = 1'b1;
   logic        req0 = 1'b0;
   logic        req1 = 1'b0;
   logic [3:0]  op0  = '0;
   logic [3:0]  op1  = '0;
   logic [31:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
   logic        gnt0, gnt1, done0, done1;
   logic [31:0] rsp_out;
   logic        rsp_neg, rsp_ovf, rsp_zero;
   logic [3:0]  alu_op;
   logic [31:0] alu_a, alu_b;
   logic [31:0] alu_out;
   logic        alu_neg, alu_overflow, alu_zero;
   logic        busy;
   logic [15:0] op_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 CLK = ~CLK;

   // returns {neg, ovf, zero, result}
   function automatic logic [34:0] alu_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] r;
      logic        v;
      v = 1'b0;
      case (op)
         OP_ADD: begin r = a + b; v = (a[31] == b[31]) && (r[31] != a[31]); end
         OP_SUB: begin r = a - b; v = (a[31] != b[31]) && (r[31] != a[31]); end
         OP_AND: r = a & b;
         OP_OR:  r = a | b;
         default: r = a ^ b;
      endcase
      return {r[31], v, (r == 32'd0), r};
   endfunction

   assign {alu_neg, alu_overflow, alu_zero, alu_out} = alu_model(alu_op, alu_a, alu_b);

   alu_arbiter dut (
      .CLK(CLK), .nRST(nRST),
      .req0(req0), .req1(req1), .op0(op0), .op1(op1),
      .a0(a0), .b0(b0), .a1(a1), .b1(b1),
      .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
      .rsp_out(rsp_out), .rsp_neg(rsp_neg), .rsp_ovf(rsp_ovf), .rsp_zero(rsp_zero),
      .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
      .alu_out(alu_out), .alu_neg(alu_neg), .alu_overflow(alu_overflow), .alu_zero(alu_zero),
      .busy(busy), .op_cnt(op_cnt)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // reference model: an operation occupies the grant cycle g plus g+1 and g+2; done at g+2
   int          cyc = 0;
   int          g_cyc = -10;
   logic        own = 1'b0;
   logic        last = 1'b1;
   logic [3:0]  m_op = '0;
   logic [31:0] m_a = '0, m_b = '0, m_rsp = '0;
   logic        m_neg = 1'b0, m_ovf = 1'b0, m_zero = 1'b0;
   logic [34:0] pend = '0;
   logic [15:0] m_cnt = '0;
   int          gnt_log[$];

   always @(negedge CLK) begin : compare
      logic fr, w1, e_g0, e_g1, e_d0, e_d1;
      cyc++;
      if (!nRST) begin
         g_cyc = -10; own = 1'b0; last = 1'b1;
         m_op = '0; m_a = '0; m_b = '0; m_rsp = '0;
         m_neg = 1'b0; m_ovf = 1'b0; m_zero = 1'b0; m_cnt = '0;
      end
      fr   = (cyc > g_cyc + 2);
      w1   = req1 && (!req0 || (RR && !last));
      e_g0 = nRST && fr && (req0 || req1) && !w1;
      e_g1 = nRST && fr && (req0 || req1) && w1;
      e_d0 = nRST && (cyc == g_cyc + 2) && !own;
      e_d1 = nRST && (cyc == g_cyc + 2) && own;
      chk("m_gnt0", 32'(gnt0), 32'(e_g0));
      chk("m_gnt1", 32'(gnt1), 32'(e_g1));
      chk("m_done0", 32'(done0), 32'(e_d0));
      chk("m_done1", 32'(done1), 32'(e_d1));
      chk("m_busy", 32'(busy), 32'(nRST && !fr));
      chk("m_alu_op", 32'(alu_op), 32'(m_op));
      chk("m_alu_a", alu_a, m_a);
      chk("m_alu_b", alu_b, m_b);
      chk("m_rsp_out", rsp_out, m_rsp);
      chk("m_rsp_flags", {29'd0, rsp_neg, rsp_ovf, rsp_zero}, {29'd0, m_neg, m_ovf, m_zero});
      chk("m_op_cnt", 32'(op_cnt), 32'(m_cnt));
      if (gnt0) gnt_log.push_back(0);
      if (gnt1) gnt_log.push_back(1);
      if (nRST) begin
         if (cyc == g_cyc + 1) {m_neg, m_ovf, m_zero, m_rsp} = pend;
         if (cyc == g_cyc + 2) m_cnt++;
         if (e_g0 || e_g1) begin
            g_cyc = cyc; own = e_g1; last = e_g1;
            m_op = e_g1 ? op1 : op0;
            m_a  = e_g1 ? a1 : a0;
            m_b  = e_g1 ? b1 : b0;
            pend = alu_model(m_op, m_a, m_b);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running at t=%0t, expected finish", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      // reset with a held request: no grant may leak
      #1 nRST = 1'b0;
      req0 = 1'b1;
      step(); #1;
      chk("rst_gnt0", 32'(gnt0), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_cnt", 32'(op_cnt), 32'd0);
      chk("rst_alu_a", alu_a, 32'd0);
      req0 = 1'b0;
      step(); nRST = 1'b1;
      step();

      // single ADD: grant at T, done at T+2
      op0 = OP_ADD; a0 = 32'h5; b0 = 32'h3; req0 = 1'b1; #1;
      chk("add_gnt0", 32'(gnt0), 32'd1);
      chk("add_gnt1", 32'(gnt1), 32'd0);
      step(); req0 = 1'b0;
      step(); #1;
      chk("add_done0", 32'(done0), 32'd1);
      chk("add_rsp", rsp_out, 32'h8);
      chk("add_zero", 32'(rsp_zero), 32'd0);
      step(); #1;
      chk("add_cnt", 32'(op_cnt), 32'd1);
      chk("add_busy", 32'(busy), 32'd0);

      // SUB flags on requester 1
      op1 = OP_SUB; a1 = 32'h7; b1 = 32'h7; req1 = 1'b1; #1;
      chk("sub_gnt1", 32'(gnt1), 32'd1);
      step(); req1 = 1'b0;
      step(); #1;
      chk("sub_done1", 32'(done1), 32'd1);
      chk("sub_done0", 32'(done0), 32'd0);
      chk("sub_rsp", rsp_out, 32'h0);
      chk("sub_zero", 32'(rsp_zero), 32'd1);
      step();
      a1 = 32'h7FFFFFFF; b1 = 32'hFFFFFFFF; req1 = 1'b1; #1;
      chk("ovf_gnt1", 32'(gnt1), 32'd1);
      step(); req1 = 1'b0;
      step(); #1;
      chk("ovf_done1", 32'(done1), 32'd1);
      chk("ovf_rsp", rsp_out, 32'h80000000);
      chk("ovf_flag", 32'(rsp_ovf), 32'd1);
      chk("ovf_neg", 32'(rsp_neg), 32'd1);
      step(); #1;
      chk("hold_rsp", rsp_out, 32'h80000000);

      // late request on requester 1 during requester 0's operation
      op0 = OP_ADD; a0 = 32'h1; b0 = 32'h2; req0 = 1'b1; #1;
      chk("late_gnt0", 32'(gnt0), 32'd1);
      step(); req0 = 1'b0;
      op1 = OP_AND; a1 = 32'h0000F0F0; b1 = 32'h0000FF00; req1 = 1'b1; #1;
      chk("late_exec_gnt1", 32'(gnt1), 32'd0);
      chk("late_exec_busy", 32'(busy), 32'd1);
      step(); #1;
      chk("late_resp_gnt1", 32'(gnt1), 32'd0);
      chk("late_done0", 32'(done0), 32'd1);
      chk("late_rsp0", rsp_out, 32'h3);
      step(); #1;
      chk("late_idle_gnt1", 32'(gnt1), 32'd1);
      step(); req1 = 1'b0;
      step(); #1;
      chk("late_done1", 32'(done1), 32'd1);
      chk("late_rsp1", rsp_out, 32'h0000F000);
      step();

      // tie: both held for four operations
      gnt_log.delete();
      op0 = OP_ADD; a0 = 32'd10; b0 = 32'd1;
      op1 = OP_SUB; a1 = 32'd10; b1 = 32'd1;
      req0 = 1'b1; req1 = 1'b1;
      repeat (12) step();
      req0 = 1'b0; req1 = 1'b0;
      step(); #1;
      chk("tie_count", 32'(gnt_log.size()), 32'd4);
      for (int i = 0; i < gnt_log.size() && i < 4; i++)
         chk($sformatf("tie_winner%0d", i), 32'(gnt_log[i]), RR ? 32'(i % 2) : 32'd0);

      // request raised in EXEC and dropped in RESP never gets a grant
      op0 = OP_OR; a0 = 32'h4; b0 = 32'h8; req0 = 1'b1; #1;
      chk("cancel_gnt0", 32'(gnt0), 32'd1);
      step(); req0 = 1'b0; req1 = 1'b1;
      step(); req1 = 1'b0; #1;
      chk("cancel_resp_gnt1", 32'(gnt1), 32'd0);
      step(); #1;
      chk("cancel_idle_gnt1", 32'(gnt1), 32'd0);
      chk("cancel_rsp", rsp_out, 32'hC);

      // reset in EXEC discards the operation
      op0 = OP_ADD; a0 = 32'd10; b0 = 32'd20; req0 = 1'b1; #1;
      chk("midrst_gnt0", 32'(gnt0), 32'd1);
      step(); req0 = 1'b0; #1;
      chk("midrst_busy_pre", 32'(busy), 32'd1);
      nRST = 1'b0; #1;
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_cnt", 32'(op_cnt), 32'd0);
      chk("midrst_rsp", rsp_out, 32'd0);
      chk("midrst_alu_a", alu_a, 32'd0);
      chk("midrst_alu_b", alu_b, 32'd0);
      step(); step(); nRST = 1'b1;
      step(); #1;
      chk("midrst_done0_a", 32'(done0), 32'd0);
      step(); #1;
      chk("midrst_done0_b", 32'(done0), 32'd0);
      chk("midrst_cnt_after", 32'(op_cnt), 32'd0);
      req0 = 1'b1; req1 = 1'b1; #1;
      chk("midrst_tie_gnt0", 32'(gnt0), 32'd1);
      chk("midrst_tie_gnt1", 32'(gnt1), 32'd0);
      step(); req0 = 1'b0; req1 = 1'b0;
      step(); step();

      // counter wrap from a preloaded value
      force dut.op_cnt = 16'hFFFE;
      m_cnt = 16'hFFFE;
      #1 release dut.op_cnt;
      step(); #1;
      chk("wrap_pre", 32'(op_cnt), 32'h0000FFFE);
      op0 = OP_ADD; a0 = 32'h0; b0 = 32'h0; req0 = 1'b1; #1;
      chk("wrap_gnt0", 32'(gnt0), 32'd1);
      step(); req0 = 1'b0;
      step(); #1;
      chk("wrap_done0", 32'(done0), 32'd1);
      chk("wrap_zero", 32'(rsp_zero), 32'd1);
      step(); #1;
      chk("wrap_ffff", 32'(op_cnt), 32'h0000FFFF);
      req0 = 1'b1;
      step(); req0 = 1'b0;
      step(); step(); #1;
      chk("wrap_zero_cnt", 32'(op_cnt), 32'h00000000);
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: CLK  in  1  system clock, rising-edge active.
REQ-002 nRST  in  1  asynchronous active-low reset.
REQ-003 req0, req1  in  1 each  requester 0/1 operation request, level held until granted.
REQ-004 op0, op1  in  4 each  ALU opcode, passed through unmodified.
REQ-005 a0, b0, a1, b1  in  32 each  requester operands.
REQ-006 gnt0, gnt1  out  1 each  one-cycle grant pulse; operands are sampled on this edge.
REQ-007 done0, done1  out  1 each  one-cycle result-valid pulse to the owning requester.
REQ-008 rsp_out  out  32  captured ALU result.
REQ-009 rsp_neg, rsp_ovf, rsp_zero  out  1 each  captured ALU negative, overflow and zero flags.
REQ-010 alu_op  out  4; alu_a, alu_b  out  32  drive to the shared ALU.
REQ-011 alu_out  in  32; alu_neg, alu_overflow, alu_zero  in  1  results from the shared combinational ALU.
REQ-012 busy  out  1  high whenever state is not IDLE.
REQ-013 op_cnt  out  16  count of completed operations.

Function
REQ-014 The block SHALL implement the states IDLE, EXEC and RESP.
REQ-015 IDLE with no req: stay in IDLE; gnt0 = gnt1 = 0.
REQ-016 IDLE with any req: gnt of the winner = 1 combinationally in that cycle; winner's op/a/b latched into alu_op/alu_a/alu_b registers; owner register set; next state EXEC.
REQ-017 EXEC: alu_out and the flags are registered into rsp_out and rsp_*; next state RESP.
REQ-018 RESP: done of the owner = 1 for exactly one cycle; op_cnt increments; next state IDLE.
REQ-019 Latency SHALL be grant in cycle T, done in cycle T+2; maximum throughput is one operation per 3 cycles.
REQ-020 A req asserted during EXEC/RESP SHALL be ignored until IDLE, with no grant issued.
REQ-021 gnt0 and gnt1 SHALL never both be high; done0 and done1 SHALL never both be high.
REQ-022 rsp_* SHALL hold their value until the next EXEC cycle.
REQ-023 alu_op/alu_a/alu_b SHALL hold their latched values outside grant cycles.
REQ-024 op_cnt SHALL wrap from 16'hFFFF to 16'h0000 with no flag.
REQ-025 Dropping a req before it is granted SHALL cancel it with no side effect.
REQ-026 Dropping a req after it is granted SHALL NOT abort the operation.

Reset
REQ-027 nRST low SHALL immediately force: state IDLE; all outputs and registers 0; owner = 1 (so requester 0 wins first).
REQ-028 Reset during EXEC or RESP SHALL discard the operation, with no done pulse after release.

Configuration
REQ-029 ALU_ARB_RR_EN defined: on simultaneous req0 and req1, grant goes to the requester not served last; a single req is granted regardless of history.
REQ-030 ALU_ARB_RR_EN undefined: fixed priority, with req0 always winning a tie.

Verification
REQ-031 Single request: req0 with op=ADD, a0=32'h5, b0=32'h3 -> gnt0 at T; done0 at T+2 with rsp_out=32'h8, rsp_zero=0; op_cnt=1.
REQ-032 Tie: req0 and req1 held with RR_EN -> grants alternate 0,1,0,1 every 3 cycles. Same test without RR_EN -> gnt0 every 3 cycles and gnt1 never.
REQ-033 Flags: req1 with op=SUB, a1=b1=32'h7 -> done1 with rsp_out=0 and rsp_zero=1. Then a1=32'h7FFFFFFF, b1=32'hFFFFFFFF with SUB -> rsp_ovf=1.
REQ-034 Reset mid-op: nRST pulsed low in EXEC -> outputs 0 immediately, no done after release, op_cnt=0, next tie granted to req0.
REQ-035 Wrap: preload or run 65536 ops -> op_cnt reads 0 after the last done.
REQ-036 Late request: req1 raised during EXEC of a req0 op -> no gnt1 until IDLE, gnt1 the cycle after done0.
